dbg_uart_rx: RTL and testbench

// - Debug-port UART receiver: deserialises 8N1 frames from the off-chip debug pin into a byte FIFO.
// - Drives the show-ahead (first-word-fall-through) FIFO read side of the UART-to-APB bridge,

---
 rtl/dbg_uart_pkg.sv | 29 ++
 rtl/dbg_sync_fifo.sv | 69 ++++++
 rtl/dbg_uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_dbg_uart_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_uart_pkg.sv
// dbg_uart_pkg: shared types and constants for the debug-port UART.
// Holds the receiver state encoding, frame geometry and the parity helper
// used when DBG_UART_RX_PARITY_EN is defined.
package dbg_uart_pkg;

    // Data bits per frame (8N1, or 8E1 with parity enabled).
    localparam int DATA_BITS      = 8;

    // Flops between the asynchronous pin and the first use of the line.
    localparam int RX_SYNC_STAGES = 2;

    // Receiver FSM states. The encoding is fixed so waveforms stay readable
    // across builds with and without the parity bit.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Even-parity bit for a data byte: the value that makes the total count
    // of ones (data plus parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dbg_sync_fifo.sv
// dbg_sync_fifo: single-clock show-ahead (first-word-fall-through) FIFO.
// The head entry is presented on o_rdata whenever the FIFO is not empty.
// Full/empty come from an occupancy counter so pointer equality is never
// ambiguous. A push while full is accepted only if a pop happens in the
// same cycle. Shared by the RX and TX paths of the debug UART.
module dbg_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == CW'(DEPTH));
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Head byte; forced to zero while empty so the output has a defined
    // reset value without resetting the storage array.
    assign o_rdata = o_empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the array has no reset; nothing reads an entry before it is
    // written, and leaving it out keeps it mappable to plain RAM cells.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbg_uart_rx.sv
// dbg_uart_rx: debug-port UART receiver feeding a show-ahead byte FIFO.
// Frames are 8N1 by default. Defining DBG_UART_RX_PARITY_EN adds an even
// parity bit (8E1), a PARITY state and the sticky o_parity_err output.
// Bytes are pushed the cycle after a good stop bit; a low stop bit sets
// o_frame_err and parks the receiver in BREAK until the line returns high.
module dbg_uart_rx
    import dbg_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic       o_fifo_empty,
    input  logic       i_fifo_read,
    output logic [7:0] o_fifo_rdata,
    output logic       o_overflow,
    output logic       o_frame_err,
    input  logic       i_clr_err
`ifdef DBG_UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    localparam int BW  = $clog2(BAUD_DIV);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    logic [RX_SYNC_STAGES-1:0] rx_sync;
    logic                      rx_s;
    rx_state_e                 state;
    logic [BW-1:0]             baud_cnt;
    logic [BCW-1:0]            bit_cnt;
    logic [DATA_BITS-1:0]      shift_reg;
    logic                      push_req;
    logic [DATA_BITS-1:0]      push_data;
    logic                      mid_bit;
    logic                      frame_set;
    logic                      overflow_set;
    logic                      fifo_full;
`ifdef DBG_UART_RX_PARITY_EN
    logic                      par_err_q;
    logic                      push_par_err;
    logic                      parity_set;
`endif

    assign rx_s    = rx_sync[RX_SYNC_STAGES-1];
    assign mid_bit = (baud_cnt == BAUD_LAST);

    // Bring the asynchronous pin into the clock domain; idle level is high.
    // NOTE: non-blocking assignments make every flop sample the value from
    // before the edge, which is what turns this chain into a real shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sync <= '1;
        end else begin
            rx_sync <= {rx_sync[RX_SYNC_STAGES-2:0], i_uart_rx};
        end
    end

    // Frame FSM: find the start edge, confirm it at half a bit, then sample
    // every following bit at its centre.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
`ifdef DBG_UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            push_par_err <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        // A line that is high again was only a glitch.
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BCW'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef DBG_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef DBG_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_bit) begin
                        baud_cnt  <= '0;
                        par_err_q <= (even_parity(shift_reg) != rx_s);
                        state     <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (mid_bit) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            push_req  <= 1'b1;
                            push_data <= shift_reg;
`ifdef DBG_UART_RX_PARITY_EN
                            push_par_err <= par_err_q;
`endif
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line is released so a long break is
                    // not decoded as a stream of 0x00 frames.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO only survives if the consumer pops that cycle.
    assign overflow_set = push_req && fifo_full && !i_fifo_read;
    assign frame_set    = (state == ST_STOP) && mid_bit && !rx_s;
`ifdef DBG_UART_RX_PARITY_EN
    assign parity_set   = push_req && push_par_err;
`endif

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef DBG_UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_overflow  <= overflow_set | (o_overflow & ~i_clr_err);
            o_frame_err <= frame_set | (o_frame_err & ~i_clr_err);
`ifdef DBG_UART_RX_PARITY_EN
            o_parity_err <= parity_set | (o_parity_err & ~i_clr_err);
`endif
        end
    end

    dbg_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_req),
        .i_wdata (push_data),
        .i_pop   (i_fifo_read),
        .o_full  (fifo_full),
        .o_empty (o_fifo_empty),
        .o_rdata (o_fifo_rdata)
    );

endmodule

// File: tb/tb_dbg_uart_rx.sv
// tb_dbg_uart_rx: self-checking bench for dbg_uart_rx (BAUD_DIV=16, FIFO_DEPTH=4).
// Table-driven single frames, hand-written corner sequences and randomized
// bursts checked against a queue model of the byte FIFO.
module tb_dbg_uart_rx;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;
`ifdef DBG_UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Cycle (counted from the start-bit drive) in which the byte is pushed:
    // 2 sync flops + 1 detect cycle + half a bit, then one bit per remaining sample.
    localparam int PUSH_CYCLE = 3 + BAUD / 2 + BAUD * (FRAME_BITS - 1);

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] fifo_rdata;
    logic       overflow;
    logic       frame_err;
    logic       clr_err;
`ifdef DBG_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        logic       exp_empty;
        logic [7:0] exp_rdata;
        logic       exp_fe;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] model_q [$];
    logic       model_ovf;

    dbg_uart_rx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_uart_rx    (uart_rx),
        .o_fifo_empty (fifo_empty),
        .i_fifo_read  (fifo_read),
        .o_fifo_rdata (fifo_rdata),
        .o_overflow   (overflow),
        .o_frame_err  (frame_err),
        .i_clr_err    (clr_err)
`ifdef DBG_UART_RX_PARITY_EN
        ,
        .o_parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; the stop bit can be held low for stop_low bit-times
    // before the line returns high. read_at / rst_at pulse those inputs in
    // the given cycle of the frame (negative = never).
    task automatic send_frame(input logic [7:0] data, input int stop_low,
                              input int read_at, input int rst_at, input logic bad_par);
        logic [FRAME_BITS-1:0] bits;
        int total;
        int b;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
`ifdef DBG_UART_RX_PARITY_EN
        bits[9] = (^data) ^ bad_par;
`endif
        bits[FRAME_BITS-1] = 1'b1;
        total = (FRAME_BITS + stop_low) * BAUD;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            b = c / BAUD;
            if (b < FRAME_BITS - 1)                 uart_rx = bits[b];
            else if (b < FRAME_BITS - 1 + stop_low) uart_rx = 1'b0;
            else                                    uart_rx = 1'b1;
            fifo_read = (c == read_at);
            rst       = (c >= rst_at) && (c < rst_at + 2);
        end
        @(negedge clk);
        uart_rx   = 1'b1;
        fifo_read = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_empty"}, fifo_empty, 1'b0);
        check({name, "_rdata"}, fifo_rdata, exp);
        fifo_read = 1'b1;
        @(negedge clk);
        fifo_read = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int n;

        rst = 1'b1; uart_rx = 1'b1; fifo_read = 1'b0; clr_err = 1'b0;
        idle(3);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_rdata", fifo_rdata, 8'h00);
        check("rst_ovf",   overflow,   1'b0);
        check("rst_fe",    frame_err,  1'b0);
`ifdef DBG_UART_RX_PARITY_EN
        check("rst_pe",    parity_err, 1'b0);
`endif
        rst = 1'b0;
        idle(2);
        check("post_rst_empty", fifo_empty, 1'b1);

        // Single-frame table.
        vecs[0] = '{8'hA5, 0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 0, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h81, 0, 1'b0, 8'h81, 1'b0};
        vecs[4] = '{8'h3C, 1, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h5A, 3, 1'b1, 8'h00, 1'b1};
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_low, -1, -100, 1'b0);
            idle(2);
            check($sformatf("tbl%0d_empty", i), fifo_empty, vecs[i].exp_empty);
            check($sformatf("tbl%0d_fe", i), frame_err, vecs[i].exp_fe);
            if (!vecs[i].exp_empty) pop_check($sformatf("tbl%0d_pop", i), vecs[i].exp_rdata);
            check($sformatf("tbl%0d_drained", i), fifo_empty, 1'b1);
            clr_pulse();
            check($sformatf("tbl%0d_fe_clr", i), frame_err, 1'b0);
        end

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, -1, -100, 1'b0);
        idle(2);
        check("ovf_set", overflow, 1'b1);
        clr_pulse();
        check("ovf_clr", overflow, 1'b0);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_pop%0d", i), 8'(i));
        check("ovf_drained", fifo_empty, 1'b1);

        // Short low glitch on the idle line, then a real frame.
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(40);
        check("glitch_empty", fifo_empty, 1'b1);
        check("glitch_fe", frame_err, 1'b0);
        send_frame(8'h6B, 0, -1, -100, 1'b0);
        idle(2);
        pop_check("glitch_next", 8'h6B);

        // Long break after 0x3C, then recovery with 0x7E.
        send_frame(8'h3C, 40, -1, -100, 1'b0);
        idle(2);
        check("break_fe", frame_err, 1'b1);
        check("break_empty", fifo_empty, 1'b1);
        clr_pulse();
        send_frame(8'h7E, 0, -1, -100, 1'b0);
        idle(2);
        check("break_fe_after", frame_err, 1'b0);
        pop_check("break_next", 8'h7E);

        // Full FIFO with a read in exactly the push cycle.
        send_frame(8'h11, 0, -1, -100, 1'b0);
        send_frame(8'h22, 0, -1, -100, 1'b0);
        send_frame(8'h33, 0, -1, -100, 1'b0);
        send_frame(8'h44, 0, -1, -100, 1'b0);
        check("full_head", fifo_rdata, 8'h11);
        send_frame(8'h55, 0, PUSH_CYCLE, -100, 1'b0);
        idle(2);
        check("full_rd_ovf", overflow, 1'b0);
        pop_check("full_rd0", 8'h22);
        pop_check("full_rd1", 8'h33);
        pop_check("full_rd2", 8'h44);
        pop_check("full_rd3", 8'h55);
        check("full_rd_empty", fifo_empty, 1'b1);

        // Reset in the middle of data bit 4 of 0xFF.
        send_frame(8'h99, 0, -1, -100, 1'b0);
        send_frame(8'hC3, 1, -1, -100, 1'b0);
        idle(2);
        check("pre_rst_fe", frame_err, 1'b1);
        check("pre_rst_empty", fifo_empty, 1'b0);
        send_frame(8'hFF, 0, -1, 5 * BAUD + BAUD / 2, 1'b0);
        idle(2);
        check("mid_rst_empty", fifo_empty, 1'b1);
        check("mid_rst_fe", frame_err, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_rdata", fifo_rdata, 8'h00);
        send_frame(8'h12, 0, -1, -100, 1'b0);
        idle(2);
        pop_check("mid_rst_next", 8'h12);
        check("mid_rst_drained", fifo_empty, 1'b1);

`ifdef DBG_UART_RX_PARITY_EN
        check("par_clean", parity_err, 1'b0);
        send_frame(8'h03, 0, -1, -100, 1'b1);
        idle(2);
        check("par_err", parity_err, 1'b1);
        pop_check("par_byte", 8'h03);
        clr_pulse();
        check("par_clr", parity_err, 1'b0);
`endif

        // Randomized bursts against a queue model of the FIFO.
        for (int it = 0; it < 8; it++) begin
            model_q.delete();
            model_ovf = 1'b0;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                send_frame(d, 0, -1, -100, 1'b0);
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else model_ovf = 1'b1;
                idle($urandom_range(0, 20));
            end
            idle(2);
            check($sformatf("rnd%0d_ovf", it), overflow, model_ovf);
            while (model_q.size() > 0) begin
                d = model_q.pop_front();
                pop_check($sformatf("rnd%0d_pop", it), d);
            end
            check($sformatf("rnd%0d_empty", it), fifo_empty, 1'b1);
            clr_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
